// File: rtl/sme_match_collector.sv
// sme_match_collector
//
// Buffers per-lane rule-ID matches from the port-group stage in small per-lane
// FIFOs and serialises them to the core through a round-robin arbiter. The
// granted head is held on match_rule_ID until match_release consumes it.
// Packet boundaries are tracked so the core learns when every match of a
// packet has been released, and how many there were.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_data           LANES slots of LANE_STRIDE bits, ID in the low ID_WIDTH bits (0 = no match)
//   in_valid, in_eop  beat valid, last beat of packet
//   in_ready          beat accepted when in_valid && in_ready
//   match_rule_ID     zero-extended ID at the granted lane FIFO head
//   match_valid       match_rule_ID is valid (some lane FIFO non-empty)
//   match_release     consume the presented match
//   pkt_done          one-cycle pulse once a packet is fully drained
//   pkt_match_cnt     releases counted for that packet (valid with pkt_done)
//   match_valid_stat  per-lane FIFO non-empty
//   drop_cnt          IDs discarded at full lanes
//
// Build option: define SME_MATCH_DROP_EN to keep in_ready high in STREAM and
// discard IDs that target a full lane (counted in drop_cnt). Without it the
// input is back-pressured while any lane FIFO is full and drop_cnt reads 0.

module sme_match_collector #(
    parameter int LANES       = 8,
    parameter int LANE_STRIDE = 16,
    parameter int ID_WIDTH    = 13,
    parameter int FIFO_DEPTH  = 4,
    parameter int OUT_WIDTH   = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [LANES*LANE_STRIDE-1:0]   in_data,
    input  logic                           in_valid,
    input  logic                           in_eop,
    output logic                           in_ready,
    output logic [OUT_WIDTH-1:0]           match_rule_ID,
    output logic                           match_valid,
    input  logic                           match_release,
    output logic                           pkt_done,
    output logic [15:0]                    pkt_match_cnt,
    output logic [LANES-1:0]               match_valid_stat,
    output logic [15:0]                    drop_cnt
);

    // state     | meaning
    // ----------+-----------------------------------------------------------
    // ST_STREAM | accepting beats (also the idle state between packets)
    // ST_DRAIN  | eop accepted, input closed, waiting for all FIFOs to empty
    // ST_DONE   | packet drained, pkt_done pulses for this single cycle

    localparam int LANE_W = $clog2(LANES);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_STREAM = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                 state_q, state_d;

    logic [ID_WIDTH-1:0]    mem_q [LANES][FIFO_DEPTH];
    logic [ID_WIDTH-1:0]    mem_d [LANES][FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q [LANES];
    logic [PTR_W-1:0]       wr_ptr_d [LANES];
    logic [PTR_W-1:0]       rd_ptr_q [LANES];
    logic [PTR_W-1:0]       rd_ptr_d [LANES];
    logic [CNT_W-1:0]       count_q  [LANES];
    logic [CNT_W-1:0]       count_d  [LANES];

    logic [LANE_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [15:0]            pkt_cnt_q, pkt_cnt_d;

    logic [ID_WIDTH-1:0]    lane_id [LANES];
    logic [LANES-1:0]       lane_has_id;
    logic [LANES-1:0]       lane_full;
    logic [LANES-1:0]       lane_nempty;
    logic [LANES-1:0]       push;
    logic [LANES-1:0]       pop;

    logic [LANE_W-1:0]      grant_idx;
    logic [LANE_W-1:0]      scan_idx;
    logic                   grant_found;
    logic                   accept;
    logic                   release_fire;

    // Bits of each lane slot above ID_WIDTH carry nothing for this block.
    logic                   unused_in_data;
    assign unused_in_data = ^in_data;

    // ------------------------------------------------------------------
    // Lane decode and FIFO status (status is from registered state only,
    // so a push in the same cycle as a pop still sees the lane as full)
    // ------------------------------------------------------------------
    always_comb begin
        for (int m = 0; m < LANES; m++) begin
            lane_id[m]     = in_data[m*LANE_STRIDE +: ID_WIDTH];
            lane_has_id[m] = |lane_id[m];
            lane_full[m]   = (count_q[m] == CNT_W'(FIFO_DEPTH));
            lane_nempty[m] = (count_q[m] != '0);
        end
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        for (int m = 0; m < LANES; m++) begin
            push[m] = accept && lane_has_id[m] && !lane_full[m];
        end
    end

    // ------------------------------------------------------------------
    // Round-robin grant: first non-empty lane at or after rr_ptr
    // ------------------------------------------------------------------
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int i = 0; i < LANES; i++) begin
            // LANES is a power of two, so the add wraps naturally.
            scan_idx = rr_ptr_q + LANE_W'(i);
            if (!grant_found && lane_nempty[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    assign release_fire = grant_found && match_release;

    always_comb begin
        for (int m = 0; m < LANES; m++) begin
            pop[m] = release_fire && (grant_idx == LANE_W'(m));
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (release_fire) begin
            rr_ptr_d = grant_idx + LANE_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Lane FIFOs
    // ------------------------------------------------------------------
    always_comb begin
        mem_d = mem_q;
        for (int m = 0; m < LANES; m++) begin
            wr_ptr_d[m] = wr_ptr_q[m];
            rd_ptr_d[m] = rd_ptr_q[m];
            count_d[m]  = count_q[m];
            if (push[m]) begin
                mem_d[m][wr_ptr_q[m]] = lane_id[m];
                wr_ptr_d[m]           = wr_ptr_q[m] + PTR_W'(1);
            end
            if (pop[m]) begin
                rd_ptr_d[m] = rd_ptr_q[m] + PTR_W'(1);
            end
            case ({push[m], pop[m]})
                2'b10:   count_d[m] = count_q[m] + CNT_W'(1);
                2'b01:   count_d[m] = count_q[m] - CNT_W'(1);
                default: count_d[m] = count_q[m];
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_STREAM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STREAM: if (accept && in_eop) state_d = ST_DRAIN;
            ST_DRAIN:  if (!(|lane_nempty)) state_d = ST_DONE;
            ST_DONE:   state_d = ST_STREAM;
            default:   state_d = ST_STREAM;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        pkt_done = 1'b0;
        case (state_q)
`ifdef SME_MATCH_DROP_EN
            ST_STREAM: in_ready = rst_n;
`else
            ST_STREAM: in_ready = rst_n && !(|lane_full);
`endif
            ST_DONE:   pkt_done = 1'b1;
            default:   ;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-packet release counter; clears as DONE is left
    // ------------------------------------------------------------------
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (state_q == ST_DONE) begin
            pkt_cnt_d = '0;
        end else if (release_fire && (pkt_cnt_q != 16'hFFFF)) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            pkt_cnt_q <= '0;
            for (int m = 0; m < LANES; m++) begin
                wr_ptr_q[m] <= '0;
                rd_ptr_q[m] <= '0;
                count_q[m]  <= '0;
            end
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
            for (int m = 0; m < LANES; m++) begin
                wr_ptr_q[m] <= wr_ptr_d[m];
                rd_ptr_q[m] <= rd_ptr_d[m];
                count_q[m]  <= count_d[m];
            end
        end
    end

    // Storage needs no reset: entries are only visible while count is nonzero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // ------------------------------------------------------------------
    // Drop accounting
    // ------------------------------------------------------------------
`ifdef SME_MATCH_DROP_EN
    localparam int DROP_W = LANE_W + 1;

    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic [DROP_W-1:0] drop_num;
    logic [16:0]       drop_sum;

    always_comb begin
        drop_num = '0;
        for (int m = 0; m < LANES; m++) begin
            if (accept && lane_has_id[m] && lane_full[m]) begin
                drop_num = drop_num + DROP_W'(1);
            end
        end
        drop_sum   = {1'b0, drop_cnt_q} + 17'(drop_num);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign match_valid      = grant_found;
    assign match_rule_ID    = grant_found ? OUT_WIDTH'(mem_q[grant_idx][rd_ptr_q[grant_idx]])
                                          : '0;
    assign match_valid_stat = lane_nempty;
    assign pkt_match_cnt    = pkt_cnt_q;

endmodule

// File: tb/tb_sme_match_collector.sv
module tb_sme_match_collector;

    localparam int LANES       = 8;
    localparam int LANE_STRIDE = 16;
    localparam int ID_WIDTH    = 13;
    localparam int FIFO_DEPTH  = 4;
    localparam int OUT_WIDTH   = 16;

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic [LANES*LANE_STRIDE-1:0] in_data;
    logic                         in_valid;
    logic                         in_eop;
    logic                         in_ready;
    logic [OUT_WIDTH-1:0]         match_rule_ID;
    logic                         match_valid;
    logic                         match_release;
    logic                         pkt_done;
    logic [15:0]                  pkt_match_cnt;
    logic [LANES-1:0]             match_valid_stat;
    logic [15:0]                  drop_cnt;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q [$];

    sme_match_collector #(
        .LANES       (LANES),
        .LANE_STRIDE (LANE_STRIDE),
        .ID_WIDTH    (ID_WIDTH),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .OUT_WIDTH   (OUT_WIDTH)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_eop           (in_eop),
        .in_ready         (in_ready),
        .match_rule_ID    (match_rule_ID),
        .match_valid      (match_valid),
        .match_release    (match_release),
        .pkt_done         (pkt_done),
        .pkt_match_cnt    (pkt_match_cnt),
        .match_valid_stat (match_valid_stat),
        .drop_cnt         (drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Move to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int m, input logic [15:0] v);
        in_data[m*LANE_STRIDE +: LANE_STRIDE] = v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_eop = 1'b0; match_release = 1'b0;
        repeat (3) tick();
        checks++;
        if ({in_ready, match_valid, pkt_done} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got ready/valid/done=%b required=000", {in_ready, match_valid, pkt_done});
        end
        checks++;
        if (match_rule_ID !== 16'h0) begin
            failures++; $display("FAIL reset_rule_id got=%h required=0000", match_rule_ID);
        end
        checks++;
        if ({pkt_match_cnt, drop_cnt, match_valid_stat} !== 40'h0) begin
            failures++;
            $display("FAIL reset_stats got cnt=%h drop=%h stat=%h required all 0", pkt_match_cnt, drop_cnt, match_valid_stat);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready_after got=%b required=1", in_ready);
        end
        tick();
    endtask

    task automatic test_basic();
        int c; int k; bit done_seen; logic [15:0] e;
        in_data = '0;
        set_lane(0, 16'h0005); set_lane(3, 16'h0123); set_lane(7, 16'h01FF);
        exp_q.push_back(16'h0005); exp_q.push_back(16'h0123); exp_q.push_back(16'h01FF);
        in_valid = 1'b1; in_eop = 1'b1;
        tick();
        in_valid = 1'b0; in_eop = 1'b0; in_data = '0; match_release = 1'b1;
        c = 1; k = 0; done_seen = 0;
        while (!done_seen && c < 40) begin
            if (match_valid) begin
                k++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL basic_extra got=%h required=no match", match_rule_ID);
                end else begin
                    e = exp_q.pop_front();
                    if (match_rule_ID !== e) begin
                        failures++; $display("FAIL basic_id got=%h required=%h", match_rule_ID, e);
                    end
                end
                checks++;
                if (c != k) begin
                    failures++; $display("FAIL basic_latency match %0d at cycle %0d required cycle %0d", k, c, k);
                end
            end
            if (pkt_done) begin
                done_seen = 1;
                checks++;
                if (c != 5) begin
                    failures++; $display("FAIL basic_done_cycle got=%0d required=5", c);
                end
                checks++;
                if (pkt_match_cnt !== 16'd3) begin
                    failures++; $display("FAIL basic_cnt got=%0d required=3", pkt_match_cnt);
                end
            end
            tick(); c++;
        end
        checks++;
        if (!done_seen || exp_q.size() != 0) begin
            failures++; $display("FAIL basic_timeout done=%0d pending=%0d required done=1 pending=0", done_seen, exp_q.size());
        end
        checks++;
        if ({pkt_done, pkt_match_cnt} !== 17'h0) begin
            failures++; $display("FAIL basic_after_done got done=%b cnt=%0d required 0/0", pkt_done, pkt_match_cnt);
        end
        match_release = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_round_robin();
        int c; bit done_seen; logic [15:0] e;
        for (int m = 0; m < LANES; m++) begin
            set_lane(m, 16'(m + 1));
            exp_q.push_back(16'(m + 1));
        end
        in_valid = 1'b1; in_eop = 1'b0;
        tick();
        match_release = 1'b1;
        c = 1; done_seen = 0;
        while (!done_seen && c < 60) begin
            if (c == 1) begin
                for (int m = 0; m < LANES; m++) begin
                    set_lane(m, 16'(m + 16'h11));
                    exp_q.push_back(16'(m + 16'h11));
                end
                in_valid = 1'b1; in_eop = 1'b1;
            end else begin
                in_valid = 1'b0; in_eop = 1'b0; in_data = '0;
            end
            if (match_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL rr_extra got=%h required=no match", match_rule_ID);
                end else begin
                    e = exp_q.pop_front();
                    if (match_rule_ID !== e) begin
                        failures++; $display("FAIL rr_order cycle %0d got=%h required=%h", c, match_rule_ID, e);
                    end
                end
            end
            if (pkt_done) begin
                done_seen = 1;
                checks++;
                if (c != 18 || pkt_match_cnt !== 16'd16) begin
                    failures++; $display("FAIL rr_done got cycle=%0d cnt=%0d required cycle=18 cnt=16", c, pkt_match_cnt);
                end
            end
            tick(); c++;
        end
        checks++;
        if (!done_seen || exp_q.size() != 0) begin
            failures++; $display("FAIL rr_timeout done=%0d pending=%0d required done=1 pending=0", done_seen, exp_q.size());
        end
        match_release = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_hold();
        logic [15:0] e;
        in_data = '0; set_lane(2, 16'h0010); exp_q.push_back(16'h0010);
        in_valid = 1'b1; in_eop = 1'b0; match_release = 1'b0;
        tick();
        in_valid = 1'b0; in_data = '0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({match_valid, match_rule_ID, match_valid_stat} !== {1'b1, 16'h0010, 8'h04}) begin
                failures++;
                $display("FAIL hold_stable cycle %0d got valid=%b id=%h stat=%h required 1/0010/04", i, match_valid, match_rule_ID, match_valid_stat);
            end
            tick();
        end
        match_release = 1'b1;
        e = exp_q.pop_front();
        checks++;
        if ({match_valid, match_rule_ID} !== {1'b1, e}) begin
            failures++; $display("FAIL hold_release got valid=%b id=%h required 1/%h", match_valid, match_rule_ID, e);
        end
        tick();
        match_release = 1'b0;
        checks++;
        if ({match_valid, match_valid_stat} !== 9'h0) begin
            failures++; $display("FAIL hold_empty got valid=%b stat=%h required 0/00", match_valid, match_valid_stat);
        end
        in_valid = 1'b1; in_eop = 1'b1;
        tick();
        in_valid = 1'b0; in_eop = 1'b0;
        tick();
        checks++;
        if ({pkt_done, pkt_match_cnt} !== {1'b1, 16'd1}) begin
            failures++; $display("FAIL hold_pkt got done=%b cnt=%0d required 1/1", pkt_done, pkt_match_cnt);
        end
        tick();
    endtask

    task automatic test_eop_only();
        in_data = '0; in_valid = 1'b1; in_eop = 1'b1;
        tick();
        in_valid = 1'b0; in_eop = 1'b0;
        checks++;
        if ({in_ready, pkt_done} !== 2'b00) begin
            failures++; $display("FAIL eop_drain got ready=%b done=%b required 0/0", in_ready, pkt_done);
        end
        tick();
        checks++;
        if ({in_ready, pkt_done, pkt_match_cnt} !== {1'b0, 1'b1, 16'd0}) begin
            failures++; $display("FAIL eop_done got ready=%b done=%b cnt=%0d required 0/1/0", in_ready, pkt_done, pkt_match_cnt);
        end
        tick();
        checks++;
        if ({in_ready, pkt_done} !== 2'b10) begin
            failures++; $display("FAIL eop_after got ready=%b done=%b required 1/0", in_ready, pkt_done);
        end
    endtask

    task automatic test_full();
        int c; bit accepted; logic [15:0] e; logic [15:0] exp_cnt;
        in_data = '0; match_release = 1'b0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            checks++;
            if (in_ready !== 1'b1) begin
                failures++; $display("FAIL full_ready_%0d got=%b required=1", k, in_ready);
            end
            set_lane(0, 16'(16'h0100 + k)); exp_q.push_back(16'(16'h0100 + k));
            in_valid = 1'b1;
            tick();
        end
        set_lane(0, 16'h0104);
`ifdef SME_MATCH_DROP_EN
        exp_cnt = 16'd4;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL full_ready_drop got=%b required=1", in_ready);
        end
        tick();
        in_valid = 1'b0; in_data = '0;
        checks++;
        if ({drop_cnt, match_valid_stat} !== {16'd1, 8'h01}) begin
            failures++; $display("FAIL full_drop got drop=%0d stat=%h required 1/01", drop_cnt, match_valid_stat);
        end
`else
        exp_cnt = 16'd5;
        exp_q.push_back(16'h0104);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b0) begin
                failures++; $display("FAIL full_backpressure cycle %0d got ready=%b required=0", i, in_ready);
            end
            tick();
        end
        checks++;
        if ({drop_cnt, match_valid_stat} !== {16'd0, 8'h01}) begin
            failures++; $display("FAIL full_nodrop got drop=%0d stat=%h required 0/01", drop_cnt, match_valid_stat);
        end
`endif
        match_release = 1'b1;
        c = 0;
        while ((exp_q.size() != 0 || match_valid || in_valid) && c < 30) begin
            accepted = in_valid && in_ready;
            if (match_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL full_extra got=%h required=no match", match_rule_ID);
                end else begin
                    e = exp_q.pop_front();
                    if (match_rule_ID !== e) begin
                        failures++; $display("FAIL full_order got=%h required=%h", match_rule_ID, e);
                    end
                end
            end
            tick(); c++;
            if (accepted) begin
                in_valid = 1'b0; in_data = '0;
            end
        end
        checks++;
        if (c >= 30) begin
            failures++; $display("FAIL full_timeout pending=%0d required=0", exp_q.size());
        end
        match_release = 1'b0; in_valid = 1'b0; in_data = '0;
        in_valid = 1'b1; in_eop = 1'b1;
        tick();
        in_valid = 1'b0; in_eop = 1'b0;
        tick();
        checks++;
        if ({pkt_done, pkt_match_cnt} !== {1'b1, exp_cnt}) begin
            failures++; $display("FAIL full_pkt got done=%b cnt=%0d required 1/%0d", pkt_done, pkt_match_cnt, exp_cnt);
        end
        tick();
        exp_q.delete();
    endtask

    task automatic test_reset_drain();
        in_data = '0;
        set_lane(1, 16'h0007); set_lane(4, 16'h0008); set_lane(6, 16'h0009);
        in_valid = 1'b1; in_eop = 1'b1; match_release = 1'b0;
        tick();
        in_valid = 1'b0; in_eop = 1'b0; in_data = '0;
        checks++;
        if ({in_ready, match_valid, match_valid_stat} !== {1'b0, 1'b1, 8'h52}) begin
            failures++; $display("FAIL rstd_pending got ready=%b valid=%b stat=%h required 0/1/52", in_ready, match_valid, match_valid_stat);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({match_valid, pkt_done, in_ready, match_valid_stat, pkt_match_cnt, drop_cnt} !== 43'h0) begin
            failures++;
            $display("FAIL rstd_cleared got valid=%b done=%b ready=%b stat=%h cnt=%0d drop=%0d required all 0", match_valid, pkt_done, in_ready, match_valid_stat, pkt_match_cnt, drop_cnt);
        end
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({in_ready, match_valid, pkt_done} !== 3'b100) begin
                failures++; $display("FAIL rstd_quiet cycle %0d got ready/valid/done=%b required=100", i, {in_ready, match_valid, pkt_done});
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_hold();
        test_eop_only();
        test_full();
        test_reset_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
